// File: rtl/token_lexer.sv
// token_lexer: streaming ASCII lexer that turns a byte stream into identifier,
// number, reserved-operator and end-of-source tokens over valid/ready handshakes.
// Optional feature: define TOKEN_LEXER_KEYWORD_EN to report the keywords
// return/if/else/for/while as reserved codes 17..21 instead of identifiers.
module token_lexer #(
  parameter int MAX_IDENT = 8,
  parameter int NUM_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   tok_valid,
  input  logic                   tok_ready,
  output logic [1:0]             tok_kind,
  output logic [4:0]             tok_op,
  output logic [NUM_W-1:0]       tok_num,
  output logic [8*MAX_IDENT-1:0] tok_name,
  output logic [4:0]             tok_len,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, IDENT, NUM, OP2, EMIT, DONE} state_t;

  localparam logic [1:0] KIND_RSV   = 2'd0;
  localparam logic [1:0] KIND_IDENT = 2'd1;
  localparam logic [1:0] KIND_NUM   = 2'd2;
  localparam logic [1:0] KIND_EOF   = 2'd3;

  state_t                 state_q, state_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [7:0]             hold_data_q, hold_data_d;
  logic [8*MAX_IDENT-1:0] acc_name_q, acc_name_d;
  logic [4:0]             acc_len_q, acc_len_d;
  logic [NUM_W-1:0]       acc_num_q, acc_num_d;
  logic [7:0]             op_char_q, op_char_d;
  logic                   tok_valid_q, tok_valid_d;
  logic [1:0]             tok_kind_q, tok_kind_d;
  logic [4:0]             tok_op_q, tok_op_d;
  logic [NUM_W-1:0]       tok_num_q, tok_num_d;
  logic [8*MAX_IDENT-1:0] tok_name_q, tok_name_d;
  logic [4:0]             tok_len_q, tok_len_d;
  logic                   err_q, err_d;

  logic       accepting;
  logic       byte_take;
  logic [7:0] idle_byte;
  logic [5:0] idle_op1;
  logic       kw_hit;
  logic [4:0] kw_code;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a) || (c == 8'h5f);
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39);
  endfunction

  function automatic logic is_ws(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h09) || (c == 8'h0a) || (c == 8'h0d);
  endfunction

  function automatic logic is_op2_lead(input logic [7:0] c);
    return (c == 8'h3d) || (c == 8'h21) || (c == 8'h3c) || (c == 8'h3e);
  endfunction

  // Returns {hit, code} for operators that are always a single character.
  function automatic logic [5:0] single_op(input logic [7:0] c);
    case (c)
      8'h2b:   return {1'b1, 5'd0};
      8'h2d:   return {1'b1, 5'd1};
      8'h2a:   return {1'b1, 5'd2};
      8'h2f:   return {1'b1, 5'd3};
      8'h28:   return {1'b1, 5'd4};
      8'h29:   return {1'b1, 5'd5};
      8'h7b:   return {1'b1, 5'd6};
      8'h7d:   return {1'b1, 5'd7};
      8'h3b:   return {1'b1, 5'd8};
      8'h2c:   return {1'b1, 5'd9};
      default: return 6'd0;
    endcase
  endfunction

  // New bytes are taken only while scanning and no holdover byte is pending;
  // the output is forced low while reset is asserted.
  assign accepting = ((state_q == IDLE) || (state_q == IDENT) || (state_q == NUM) ||
                      (state_q == OP2)) && !hold_valid_q;
  assign in_ready  = rst_n && accepting;
  assign byte_take = in_valid && accepting;
  assign idle_byte = hold_valid_q ? hold_data_q : in_data;
  assign idle_op1  = single_op(idle_byte);

`ifdef TOKEN_LEXER_KEYWORD_EN
  // Word literals are stored MSB-first, so char i sits at byte (wlen-1-i).
  function automatic logic kw_match(input logic [8*MAX_IDENT-1:0] name, input logic [4:0] len,
                                    input logic [47:0] word, input int wlen);
    logic ok;
    ok = (len == 5'(wlen)) && (wlen <= MAX_IDENT);
    for (int i = 0; i < 6; i++)
      if (i < wlen && i < MAX_IDENT && name[i*8 +: 8] != word[(wlen-1-i)*8 +: 8]) ok = 1'b0;
    return ok;
  endfunction

  // Recognise the finished identifier as one of the reserved keywords.
  always_comb begin
    kw_hit  = 1'b1;
    kw_code = 5'd0;
    if (kw_match(acc_name_q, acc_len_q, 48'("return"), 6))     kw_code = 5'd17;
    else if (kw_match(acc_name_q, acc_len_q, 48'("if"), 2))    kw_code = 5'd18;
    else if (kw_match(acc_name_q, acc_len_q, 48'("else"), 4))  kw_code = 5'd19;
    else if (kw_match(acc_name_q, acc_len_q, 48'("for"), 3))   kw_code = 5'd20;
    else if (kw_match(acc_name_q, acc_len_q, 48'("while"), 5)) kw_code = 5'd21;
    else kw_hit = 1'b0;
  end
`else
  assign kw_hit  = 1'b0;
  assign kw_code = 5'd0;
`endif

  // Next-state logic: scan bytes, build tokens, and hold them until consumed.
  // Token fields are zero whenever tok_valid is low, so emitting only sets the
  // fields meaningful for that kind.
  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    acc_name_d   = acc_name_q;
    acc_len_d    = acc_len_q;
    acc_num_d    = acc_num_q;
    op_char_d    = op_char_q;
    tok_valid_d  = tok_valid_q;
    tok_kind_d   = tok_kind_q;
    tok_op_d     = tok_op_q;
    tok_num_d    = tok_num_q;
    tok_name_d   = tok_name_q;
    tok_len_d    = tok_len_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (hold_valid_q || byte_take) begin
          hold_valid_d = 1'b0;
          if (is_ws(idle_byte)) begin
            state_d = IDLE;
          end else if (is_letter(idle_byte)) begin
            state_d        = IDENT;
            acc_name_d     = '0;
            acc_name_d[7:0] = idle_byte;
            acc_len_d      = 5'd1;
          end else if (is_digit(idle_byte)) begin
            state_d   = NUM;
            acc_num_d = NUM_W'(idle_byte[3:0]);
          end else if (is_op2_lead(idle_byte)) begin
            state_d   = OP2;
            op_char_d = idle_byte;
          end else if (idle_byte == 8'h00) begin
            state_d     = EMIT;
            tok_valid_d = 1'b1;
            tok_kind_d  = KIND_EOF;
          end else if (idle_op1[5]) begin
            state_d     = EMIT;
            tok_valid_d = 1'b1;
            tok_kind_d  = KIND_RSV;
            tok_op_d    = idle_op1[4:0];
          end else begin
            err_d = 1'b1;
          end
        end
      end

      IDENT: begin
        if (byte_take) begin
          if (is_letter(in_data) || is_digit(in_data)) begin
            for (int i = 0; i < MAX_IDENT; i++)
              if (acc_len_q == 5'(i)) acc_name_d[i*8 +: 8] = in_data;
            if (acc_len_q != 5'd31) acc_len_d = acc_len_q + 5'd1;
          end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            state_d      = EMIT;
            tok_valid_d  = 1'b1;
            if (kw_hit) begin
              tok_kind_d = KIND_RSV;
              tok_op_d   = kw_code;
            end else begin
              tok_kind_d = KIND_IDENT;
              tok_name_d = acc_name_q;
              tok_len_d  = acc_len_q;
            end
          end
        end
      end

      NUM: begin
        if (byte_take) begin
          if (is_digit(in_data)) begin
            acc_num_d = (acc_num_q << 3) + (acc_num_q << 1) + NUM_W'(in_data[3:0]);
          end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            state_d      = EMIT;
            tok_valid_d  = 1'b1;
            tok_kind_d   = KIND_NUM;
            tok_num_d    = acc_num_q;
          end
        end
      end

      OP2: begin
        if (byte_take) begin
          if (in_data == 8'h3d) begin
            state_d     = EMIT;
            tok_valid_d = 1'b1;
            tok_kind_d  = KIND_RSV;
            case (op_char_q)
              8'h3d:   tok_op_d = 5'd11;
              8'h21:   tok_op_d = 5'd12;
              8'h3c:   tok_op_d = 5'd14;
              default: tok_op_d = 5'd16;
            endcase
          end else begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            if (op_char_q == 8'h21) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d     = EMIT;
              tok_valid_d = 1'b1;
              tok_kind_d  = KIND_RSV;
              case (op_char_q)
                8'h3d:   tok_op_d = 5'd10;
                8'h3c:   tok_op_d = 5'd13;
                default: tok_op_d = 5'd15;
              endcase
            end
          end
        end
      end

      EMIT: begin
        if (tok_ready) begin
          state_d     = (tok_kind_q == KIND_EOF) ? DONE : IDLE;
          tok_valid_d = 1'b0;
          tok_kind_d  = '0;
          tok_op_d    = '0;
          tok_num_d   = '0;
          tok_name_d  = '0;
          tok_len_d   = '0;
        end
      end

      default: begin
        state_d = DONE;
      end
    endcase
  end

  // State and output registers; reset discards any partial or pending token.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      acc_name_q   <= '0;
      acc_len_q    <= '0;
      acc_num_q    <= '0;
      op_char_q    <= '0;
      tok_valid_q  <= 1'b0;
      tok_kind_q   <= '0;
      tok_op_q     <= '0;
      tok_num_q    <= '0;
      tok_name_q   <= '0;
      tok_len_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      acc_name_q   <= acc_name_d;
      acc_len_q    <= acc_len_d;
      acc_num_q    <= acc_num_d;
      op_char_q    <= op_char_d;
      tok_valid_q  <= tok_valid_d;
      tok_kind_q   <= tok_kind_d;
      tok_op_q     <= tok_op_d;
      tok_num_q    <= tok_num_d;
      tok_name_q   <= tok_name_d;
      tok_len_q    <= tok_len_d;
      err_q        <= err_d;
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_kind  = tok_kind_q;
  assign tok_op    = tok_op_q;
  assign tok_num   = tok_num_q;
  assign tok_name  = tok_name_q;
  assign tok_len   = tok_len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_token_lexer.sv
// tb_token_lexer: table-driven bench for token_lexer. Each vector is a source
// string (terminated with 0x00 by the driver) and the expected token list,
// written as "kind/op/num/name/len" entries separated by spaces.
module tb_token_lexer;

  localparam int MAX_IDENT = 8;
  localparam int NUM_W     = 32;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   in_valid = 1'b0;
  logic [7:0]             in_data = 8'h00;
  logic                   in_ready;
  logic                   tok_valid;
  logic                   tok_ready = 1'b1;
  logic [1:0]             tok_kind;
  logic [4:0]             tok_op;
  logic [NUM_W-1:0]       tok_num;
  logic [8*MAX_IDENT-1:0] tok_name;
  logic [4:0]             tok_len;
  logic                   err;

  token_lexer #(.MAX_IDENT(MAX_IDENT), .NUM_W(NUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_op(tok_op), .tok_num(tok_num),
    .tok_name(tok_name), .tok_len(tok_len), .err(err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct {
    string src;
    string exp;
    logic  err;
    int    stall;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void addVec(input string src, input string exp, input logic e, input int stall);
    vec_t v;
    v.src = src; v.exp = exp; v.err = e; v.stall = stall;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input string got, input string want);
    n_vec++;
    if (got != want) begin
      n_miss++;
      $display("[TB] FAIL %s: got '%s' expected '%s'", name, got, want);
    end
  endtask

  // Renders the current token fields; zero bytes inside the name show as '.'.
  function automatic string fmtTok();
    string nm = "";
    int last = -1;
    for (int i = 0; i < MAX_IDENT; i++) if (tok_name[i*8 +: 8] != 8'h00) last = i;
    for (int i = 0; i <= last; i++)
      nm = (tok_name[i*8 +: 8] == 8'h00) ? {nm, "."} : $sformatf("%s%c", nm, tok_name[i*8 +: 8]);
    return $sformatf("%0d/%0d/%0d/%s/%0d", tok_kind, tok_op, tok_num, nm, tok_len);
  endfunction

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; tok_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feedByte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    @(posedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input bit do_reset, input string tag);
    logic [7:0] bytes[$];
    string got = "", snap = "";
    int idx = 0, cyc = 0, stall_cnt = 0;
    bit eof = 0, unstable = 0, take, busy = 0;
    for (int i = 0; i < v.src.len(); i++) bytes.push_back(v.src[i]);
    bytes.push_back(8'h00);
    if (do_reset) pulseReset();
    while (!eof && cyc < 400) begin
      @(negedge clk);
      cyc++;
      in_valid = (idx < bytes.size());
      in_data  = in_valid ? bytes[idx] : 8'h00;
      if (tok_valid && stall_cnt < v.stall) begin
        tok_ready = 1'b0;
        if (stall_cnt == 0) snap = fmtTok();
        else if (fmtTok() != snap) unstable = 1;
        if (in_ready) unstable = 1;
        stall_cnt++;
      end else begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          got = (got == "") ? fmtTok() : {got, " ", fmtTok()};
          stall_cnt = 0;
          if (tok_kind == 2'd3) eof = 1;
        end
      end
      take = in_valid && in_ready;
      @(posedge clk);
      if (take) idx++;
    end
    if (!eof) checkOutput({tag, " timeout"}, "no eof", "eof");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'h61;
      if (in_ready || tok_valid) busy = 1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, " tokens"}, got, v.exp);
    checkOutput({tag, " err"}, $sformatf("%0b", err), $sformatf("%0b", v.err));
    checkOutput({tag, " done"}, $sformatf("%0b", busy), "0");
    if (v.stall > 0) checkOutput({tag, " stall"}, $sformatf("%0b", unstable), "0");
  endtask

  // Safety net in case something hangs outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got 'timeout' expected 'finish'");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, vector table, then the mid-token reset case.
  initial begin
    vec_t v;
    addVec("a1=42;", "1/0/0/a1/2 0/10/0//0 2/0/42//0 0/8/0//0 3/0/0//0", 1'b0, 0);
    addVec("x<=y!=3", "1/0/0/x/1 0/14/0//0 1/0/0/y/1 0/12/0//0 2/0/3//0 3/0/0//0", 1'b0, 0);
    addVec("a< b", "1/0/0/a/1 0/13/0//0 1/0/0/b/1 3/0/0//0", 1'b0, 0);
    addVec("a==b", "1/0/0/a/1 0/11/0//0 1/0/0/b/1 3/0/0//0", 1'b0, 0);
`ifdef TOKEN_LEXER_KEYWORD_EN
    addVec("while", "0/21/0//0 3/0/0//0", 1'b0, 0);
    addVec("if else ifx", "0/18/0//0 0/19/0//0 1/0/0/ifx/3 3/0/0//0", 1'b0, 0);
`else
    addVec("while", "1/0/0/while/5 3/0/0//0", 1'b0, 0);
    addVec("if else ifx", "1/0/0/if/2 1/0/0/else/4 1/0/0/ifx/3 3/0/0//0", 1'b0, 0);
`endif
    addVec("abcdefghij", "1/0/0/abcdefgh/10 3/0/0//0", 1'b0, 0);
    addVec("abcdefghijklmnopqrstuvwxyzabcdefghijklmn", "1/0/0/abcdefgh/31 3/0/0//0", 1'b0, 0);
    addVec("4294967297", "2/0/1//0 3/0/0//0", 1'b0, 0);
    addVec("12+", "2/0/12//0 0/0/0//0 3/0/0//0", 1'b0, 5);
    addVec("1 @ 2", "2/0/1//0 2/0/2//0 3/0/0//0", 1'b1, 0);
    addVec("!a", "1/0/0/a/1 3/0/0//0", 1'b1, 0);
    addVec("\t7\n+ 8", "2/0/7//0 0/0/0//0 2/0/8//0 3/0/0//0", 1'b0, 0);
    addVec("(x_9)*{}-/,>>=",
           "0/4/0//0 1/0/0/x_9/3 0/5/0//0 0/2/0//0 0/6/0//0 0/7/0//0 0/1/0//0 0/3/0//0 0/9/0//0 0/15/0//0 0/16/0//0 3/0/0//0",
           1'b0, 0);

    #2;
    checkOutput("reset in_ready", $sformatf("%0b", in_ready), "0");
    checkOutput("reset tok_valid", $sformatf("%0b", tok_valid), "0");
    checkOutput("reset fields", fmtTok(), "0/0/0//0");
    checkOutput("reset err", $sformatf("%0b", err), "0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset in_ready", $sformatf("%0b", in_ready), "1");

    foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));

    pulseReset();
    feedByte(8'h40);
    feedByte(8'h61);
    feedByte(8'h62);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("pre-reset err", $sformatf("%0b", err), "1");
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset tok_valid", $sformatf("%0b", tok_valid), "0");
    checkOutput("mid reset err", $sformatf("%0b", err), "0");
    rst_n = 1'b1;
    v.src = "7"; v.exp = "2/0/7//0 3/0/0//0"; v.err = 1'b0; v.stall = 0;
    applyStimulus(v, 1'b0, "after-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/token_lexer.md
TOKEN_LEXER -- requirements
Module: token_lexer

Interface
REQ-001 SHALL have parameter MAX_IDENT, default 8, meaning maximum identifier characters stored (1..16).
REQ-002 SHALL have parameter NUM_W, default 32, meaning width of the numeric literal value.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  source byte valid.
REQ-006 SHALL have port in_data  input  8  ASCII source byte; 0x00 = end of source.
REQ-007 SHALL have port in_ready  output  1  lexer accepts in_data when in_valid && in_ready.
REQ-008 SHALL have port tok_valid  output  1  token fields valid.
REQ-009 SHALL have port tok_ready  input  1  consumer takes token when tok_valid && tok_ready.
REQ-010 SHALL have port tok_kind  output  2  0 reserved, 1 ident, 2 num, 3 eof.
REQ-011 SHALL have port tok_op  output  5  reserved code: + 0, - 1, * 2, / 3, ( 4, ) 5, { 6, } 7, ; 8, `,` 9, = 10, == 11, != 12, < 13, <= 14, > 15, >= 16, return 17, if 18, else 19, for 20, while 21.
REQ-012 SHALL have port tok_num  output  NUM_W  numeric literal value.
REQ-013 SHALL have port tok_name  output  8*MAX_IDENT  identifier characters, first char in bits [7:0], unused bytes zero.
REQ-014 SHALL have port tok_len  output  5  identifier length, saturating at 31.
REQ-015 SHALL have port err  output  1  sticky: illegal character seen.

Function
REQ-016 SHALL use states IDLE, IDENT, NUM, OP2, EMIT, DONE.
REQ-017 IDLE: whitespace (0x20, 0x09, 0x0A, 0x0D) consumed and discarded; letter or '_' -> IDENT; digit -> NUM; '=', '!', '<', '>' -> OP2; other single-char operator -> EMIT; 0x00 -> EMIT as eof.
REQ-018 IDENT SHALL accept letters, digits and '_'; NUM SHALL accept digits, value = value*10 + digit, wrapping modulo 2^NUM_W.
REQ-019 Any byte that ends an IDENT/NUM/OP2 token SHALL be accepted into a one-byte holdover register and re-dispatched from IDLE after the token is consumed, without asserting in_ready.
REQ-020 OP2: following '=' forms the two-char operator and is consumed; any other byte goes to holdover; lone '!' SHALL set err and emit no token.
REQ-021 in_ready SHALL be high only in IDLE, IDENT, NUM, OP2 with holdover empty.
REQ-022 tok_valid SHALL rise the cycle after the terminating byte is accepted; fields SHALL stay stable while tok_valid && !tok_ready.
REQ-023 Characters beyond MAX_IDENT SHALL be dropped from tok_name while tok_len keeps counting.
REQ-024 Illegal byte SHALL set err, be discarded, and lexing SHALL continue in IDLE.
REQ-025 After the eof token is consumed the lexer SHALL enter DONE, hold in_ready low and tok_valid low until reset.
REQ-026 Fields not meaningful for tok_kind SHALL be zero.

Reset
REQ-027 On rst_n low: state IDLE, holdover empty, in_ready 0 during reset then 1, tok_valid 0, tok_kind/tok_op/tok_num/tok_name/tok_len 0, err 0.
REQ-028 Reset mid-token or mid-handshake SHALL discard the partial token and pending token.

Configuration
REQ-029 With TOKEN_LEXER_KEYWORD_EN defined, identifiers exactly equal to return/if/else/for/while SHALL be emitted as kind 0 with tok_op 17..21; without it they SHALL be emitted as kind 1 identifiers; all else identical.

Verification
REQ-030 "a1=42;" then 0x00 -> ident "a1" len 2, reserved 10, num 42, reserved 8, eof; err 0.
REQ-031 "x<=y!=3" -> ident x, op 14, ident y, op 12, num 3; and "a< b" -> op 13.
REQ-032 "while" with macro -> kind 0 op 21; without macro -> kind 1 name "while" len 5.
REQ-033 "abcdefghij" (MAX_IDENT 8) -> tok_name "abcdefgh", tok_len 10; "4294967297" -> tok_num 1.
REQ-034 tok_ready held low 5 cycles on "12+" -> num 12 stable, in_ready low, no bytes lost, then op 0.
REQ-035 "1 @ 2" -> num 1, num 2, err 1; rst_n pulsed mid-"abc" -> err 0, next "7" yields num 7.
